mac_accumulator_8bit: RTL and testbench

//   Sequential multiply-accumulate stage wrapped around the combinational 8x8 array multiplier.
//   - Accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake.
//   - Registers each 16-bit product and sums the products of one vector (terminated by in_last)

---
 rtl/mac_accumulator_8bit_pkg.sv | 14 +
 rtl/mac_accumulator_8bit_if.sv | 32 +++
 rtl/mac_accumulator_8bit_mult.sv | 21 ++
 rtl/mac_accumulator_8bit.sv | 116 +++++++++++
 tb/tb_mac_accumulator_8bit.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_accumulator_8bit_pkg.sv
// Shared types and widths for the multiply-accumulate block.
//   PROD_W      width of the 8x8 product
//   OPER_W      width of each operand
//   mac_state_t controller states: IDLE, ACCUM, DONE
package mac_pkg;
    localparam int PROD_W = 16;
    localparam int OPER_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;
endpackage

// File: rtl/mac_accumulator_8bit_if.sv
// Handshake bundle for mac_accumulator_8bit.
//   Input side : in_valid, in_ready, in_a, in_b, in_last
//   Output side: out_valid, out_ready, out_data, out_count, out_ovf
//   master modport: the producer/consumer around the block
//   slave modport : the block itself
interface mac_accumulator_8bit_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    import mac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OPER_W-1:0] in_a;
    logic [OPER_W-1:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/mac_accumulator_8bit_mult.sv
// Combinational unsigned 8x8 array multiplier.
//   i_a, i_b : 8-bit unsigned operands
//   o_p      : 16-bit product
// Each row adds the partial product a & b[i], shifted by i, to the running sum.
module array_multiplier_8bit
    import mac_pkg::*;
(
    input  logic [OPER_W-1:0] i_a,
    input  logic [OPER_W-1:0] i_b,
    output logic [PROD_W-1:0] o_p
);
    logic [PROD_W-1:0] w_row [0:OPER_W];

    assign w_row[0] = '0;

    for (genvar i = 0; i < OPER_W; i++) begin : g_row
        assign w_row[i+1] = w_row[i] + (PROD_W'(i_a & {OPER_W{i_b[i]}}) << i);
    end

    assign o_p = w_row[OPER_W];
endmodule

// File: rtl/mac_accumulator_8bit.sv
// Two-stage multiply-accumulate: registers each operand-pair product, then sums
// products of one vector (terminated by in_last) into an ACC_W-bit accumulator
// and presents the sum and term count over a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mac_accumulator_8bit_if slave (operand input, result output)
// Macro MAC_SATURATE_EN: defined -> saturating accumulation; undefined -> wrapping.
// In both builds out_ovf flags an overflow of the accumulator, sticky until the
// result is consumed.
module mac_accumulator_8bit
    import mac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mac_accumulator_8bit_if.slave  bus
);
    mac_state_t        r_state;
    logic [PROD_W-1:0] r_prod;
    logic              r_last;
    logic              r_pvld;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_data;
    logic [CNT_W-1:0]  r_out_count;

    logic [PROD_W-1:0] w_prod;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_out_hs;
    logic [ACC_W:0]    w_sum;
    logic              w_carry;
    logic [ACC_W-1:0]  w_acc_next;
    logic [CNT_W-1:0]  w_cnt_next;

    array_multiplier_8bit u_mult (
        .i_a (bus.in_a),
        .i_b (bus.in_b),
        .o_p (w_prod)
    );

    // Input closes once the final term is in stage 2 and stays closed in DONE,
    // so a new vector never mixes with an unconsumed result.
    assign w_in_ready = rst_n && (r_state != DONE) && !(r_pvld && r_last);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;

    // One extra bit catches the carry out of the ACC_W-bit add.
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_prod};
    assign w_carry    = w_sum[ACC_W];
    assign w_cnt_next = r_cnt + CNT_W'(1);

`ifdef MAC_SATURATE_EN
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prod      <= '0;
            r_last      <= 1'b0;
            r_pvld      <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else begin
            // Stage 1: capture product of the accepted pair.
            r_pvld <= w_accept;
            if (w_accept) begin
                r_prod <= w_prod;
                r_last <= bus.in_last;
            end

            case (r_state)
                IDLE:    if (w_accept)          r_state <= ACCUM;
                ACCUM:   if (r_pvld && r_last)  r_state <= DONE;
                DONE:    if (w_out_hs)          r_state <= IDLE;
                default:                        r_state <= IDLE;
            endcase

            // Stage 2: accumulate, and publish the result on the final term.
            if (r_pvld) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (w_carry) r_ovf <= 1'b1;
                if (r_last) begin
                    r_out_data  <= w_acc_next;
                    r_out_count <= w_cnt_next;
                    r_out_valid <= 1'b1;
                end
            end

            // Result consumed: start the next vector from a clean accumulator.
            if (w_out_hs) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_ovf       <= 1'b0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_mac_accumulator_8bit.sv
// Self-checking bench: drives a 24-bit and a 16-bit accumulator instance with the
// same stream and compares both against a sum-of-products reference model.
module tb_mac_accumulator_8bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;

    always #5 clk = ~clk;

    mac_accumulator_8bit_if #(.ACC_W(24), .CNT_W(8)) b24 ();
    mac_accumulator_8bit_if #(.ACC_W(16), .CNT_W(8)) b16 ();

    assign b24.in_valid = in_valid;  assign b16.in_valid = in_valid;
    assign b24.in_a = in_a;          assign b16.in_a = in_a;
    assign b24.in_b = in_b;          assign b16.in_b = in_b;
    assign b24.in_last = in_last;    assign b16.in_last = in_last;
    assign b24.out_ready = out_ready; assign b16.out_ready = out_ready;

    mac_accumulator_8bit #(.ACC_W(24), .CNT_W(8)) dut24 (.clk(clk), .rst_n(rst_n), .bus(b24.slave));
    mac_accumulator_8bit #(.ACC_W(16), .CNT_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    int vectors = 0;
    int errors  = 0;

    // Operand pairs of the vector currently in flight.
    int unsigned va[$];
    int unsigned vb[$];

    typedef struct packed {
        logic        v;
        logic [23:0] d24;
        logic [7:0]  c24;
        logic        o24;
        logic [15:0] d16;
        logic [7:0]  c16;
        logic        o16;
        logic        v16;
        int          lat;
    } res_t;

    function automatic longint unsigned model_sum();
        longint unsigned s = 0;
        foreach (va[i]) s += longint'(va[i]) * longint'(vb[i]);
        return s;
    endfunction

    function automatic longint unsigned model_data(input int w);
        longint unsigned mx = (64'd1 << w) - 1;
        longint unsigned s  = model_sum();
`ifdef MAC_SATURATE_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    function automatic logic model_ovf(input int w);
        return model_sum() > ((64'd1 << w) - 1);
    endfunction

    // Presents one beat and holds it until accepted; returns cycles stalled.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last,
                             output int waits);
        logic ok;
        waits = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            ok = b24.in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                in_valid = 1'b0; in_last = 1'b0;
                va.push_back(a); vb.push_back(b);
                return;
            end
            waits++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        vectors++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
    endtask

    // Waits for out_valid with out_ready high, captures both instances, completes the handshake.
    task automatic collect(output res_t r);
        r = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b24.out_valid) begin
                r.v = 1'b1; r.v16 = b16.out_valid;
                r.d24 = b24.out_data; r.c24 = b24.out_count; r.o24 = b24.out_ovf;
                r.d16 = b16.out_data; r.c16 = b16.out_count; r.o16 = b16.out_ovf;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                return;
            end
            r.lat++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({b24.out_valid, b24.out_data, b24.out_count, b24.out_ovf, b24.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset24: got v=%0b d=%0d c=%0d o=%0b r=%0b, required all 0",
                     b24.out_valid, b24.out_data, b24.out_count, b24.out_ovf, b24.in_ready);
        end
        vectors++;
        if ({b16.out_valid, b16.out_data, b16.out_count, b16.out_ovf, b16.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset16: got v=%0b d=%0d c=%0d o=%0b r=%0b, required all 0",
                     b16.out_valid, b16.out_data, b16.out_count, b16.out_ovf, b16.in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (b24.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %0b, required 1", b24.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int w0, w1;
        res_t r;
        va.delete(); vb.delete();
        send_beat(8'd3, 8'd5, 1'b0, w0);
        send_beat(8'd255, 8'd255, 1'b1, w1);
        vectors++;
        if (w1 != 0) begin
            errors++;
            $display("FAIL b2b_stall: got %0d stall cycles, required 0", w1);
        end
        collect(r);
        vectors++;
        if (!r.v || r.lat != 1) begin
            errors++;
            $display("FAIL b2b_latency: got valid=%0b lat=%0d, required valid=1 lat=1", r.v, r.lat);
        end
        vectors++;
        if (r.d24 !== 24'd65040 || r.c24 !== 8'd2 || r.o24 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: got d=%0d c=%0d o=%0b, required d=65040 c=2 o=0",
                     r.d24, r.c24, r.o24);
        end
        vectors++;
        if (r.d16 !== 16'(model_data(16)) || r.o16 !== model_ovf(16)) begin
            errors++;
            $display("FAIL b2b_result16: got d=%0d o=%0b, required d=%0d o=%0b",
                     r.d16, r.o16, model_data(16), model_ovf(16));
        end
    endtask

    task automatic test_overflow();
        int w;
        res_t r;
        logic [15:0] exp16;
`ifdef MAC_SATURATE_EN
        exp16 = 16'd65535;
`else
        exp16 = 16'd64514;
`endif
        va.delete(); vb.delete();
        send_beat(8'd255, 8'd255, 1'b0, w);
        send_beat(8'd255, 8'd255, 1'b1, w);
        collect(r);
        vectors++;
        if (!r.v16 || r.d16 !== exp16 || r.o16 !== 1'b1 || r.c16 !== 8'd2) begin
            errors++;
            $display("FAIL ovf16: got v=%0b d=%0d c=%0d o=%0b, required v=1 d=%0d c=2 o=1",
                     r.v16, r.d16, r.c16, r.o16, exp16);
        end
        vectors++;
        if (r.d24 !== 24'd130050 || r.o24 !== 1'b0) begin
            errors++;
            $display("FAIL ovf24: got d=%0d o=%0b, required d=130050 o=0", r.d24, r.o24);
        end
    endtask

    task automatic test_backpressure();
        int w;
        va.delete(); vb.delete();
        send_beat(8'd0, 8'd77, 1'b1, w);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (b24.out_valid !== 1'b1 || b24.out_data !== 24'd0 || b24.out_count !== 8'd1 ||
                b24.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%0b d=%0d c=%0d r=%0b, required v=1 d=0 c=1 r=0",
                         k, b24.out_valid, b24.out_data, b24.out_count, b24.in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (b24.in_ready !== 1'b1 || b24.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got r=%0b v=%0b, required r=1 v=0", b24.in_ready, b24.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bubbles();
        int w;
        res_t r;
        va.delete(); vb.delete();
        send_beat(8'd2, 8'd3, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        send_beat(8'd4, 8'd5, 1'b1, w);
        collect(r);
        vectors++;
        if (r.d24 !== 24'd26 || r.c24 !== 8'd2 || r.d16 !== 16'd26) begin
            errors++;
            $display("FAIL bubbles: got d24=%0d c=%0d d16=%0d, required 26 2 26", r.d24, r.c24, r.d16);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        res_t r;
        va.delete(); vb.delete();
        send_beat(8'd10, 8'd10, 1'b0, w);
        send_beat(8'd10, 8'd10, 1'b0, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({b24.out_valid, b24.out_data, b24.out_count, b24.out_ovf, b24.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%0b d=%0d c=%0d o=%0b r=%0b, required all 0",
                     b24.out_valid, b24.out_data, b24.out_count, b24.out_ovf, b24.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        va.delete(); vb.delete();
        send_beat(8'd1, 8'd1, 1'b1, w);
        collect(r);
        vectors++;
        if (r.d24 !== 24'd1 || r.c24 !== 8'd1 || r.d16 !== 16'd1) begin
            errors++;
            $display("FAIL after_reset: got d24=%0d c=%0d d16=%0d, required 1 1 1", r.d24, r.c24, r.d16);
        end
    endtask

    // 260 full-scale terms: count wraps to 4 and the 24-bit accumulator overflows.
    task automatic test_long();
        int w;
        res_t r;
        va.delete(); vb.delete();
        for (int k = 0; k < 260; k++) send_beat(8'd255, 8'd255, (k == 259), w);
        collect(r);
        vectors++;
        if (r.c24 !== 8'd4 || r.d24 !== 24'(model_data(24)) || r.o24 !== 1'b1) begin
            errors++;
            $display("FAIL long24: got d=%0d c=%0d o=%0b, required d=%0d c=4 o=1",
                     r.d24, r.c24, r.o24, model_data(24));
        end
    endtask

    task automatic test_random();
        int w, len;
        res_t r;
        for (int v = 0; v < 20; v++) begin
            va.delete(); vb.delete();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                send_beat(8'($urandom), 8'($urandom), (k == len - 1), w);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            collect(r);
            vectors++;
            if (!r.v || r.d24 !== 24'(model_data(24)) || r.c24 !== 8'(len) ||
                r.o24 !== model_ovf(24)) begin
                errors++;
                $display("FAIL rand24_%0d: got v=%0b d=%0d c=%0d o=%0b, required d=%0d c=%0d o=%0b",
                         v, r.v, r.d24, r.c24, r.o24, model_data(24), len, model_ovf(24));
            end
            vectors++;
            if (!r.v16 || r.d16 !== 16'(model_data(16)) || r.c16 !== 8'(len) ||
                r.o16 !== model_ovf(16)) begin
                errors++;
                $display("FAIL rand16_%0d: got v=%0b d=%0d c=%0d o=%0b, required d=%0d c=%0d o=%0b",
                         v, r.v16, r.d16, r.c16, r.o16, model_data(16), len, model_ovf(16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_long();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
